// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue logic.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    localparam logic [31:0] STATUS_MULT_OVF = 32'd4;
    localparam logic [31:0] STATUS_DIV_EXC  = 32'd5;
    localparam logic [31:0] STATUS_TIMEOUT  = 32'd6;
    localparam logic [4:0]  RSTATUS_REG     = 5'd30;

    function automatic logic [31:0] exc_status(input logic is_div);
        return is_div ? STATUS_DIV_EXC : STATUS_MULT_OVF;
    endfunction

endpackage

// File: rtl/multdiv_watchdog.sv
// BUSY-state cycle counter; flags a timeout on the TIMEOUT_CYCLES-th BUSY cycle without ready.
module multdiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic busy_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!busy_i) begin
            cnt_d = '0;
        end else if (!ready_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready in the same cycle always beats the timeout.
    assign timeout_o = busy_i && !ready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Execute-stage initiator for the iterative multiply/divide unit.
// Optional BUSY watchdog enabled by defining MULTDIV_ISSUE_TIMEOUT_EN.
module multdiv_issue #(
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [4:0] RSTATUS_REG    = multdiv_pkg::RSTATUS_REG
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    input  logic        flush,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    import multdiv_pkg::*;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    md_state_e   state_q;
    logic        is_div_q;
    logic [4:0]  rd_q;
    logic [31:0] opa_q, opb_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        wb_exc_q;
    logic        accept;
    logic        timeout_w;

    assign accept = issue_valid && !flush;

`ifdef MULTDIV_ISSUE_TIMEOUT_EN
    multdiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .busy_i    (state_q == BUSY),
        .ready_i   (md_resultRDY),
        .timeout_o (timeout_w)
    );
`else
    assign timeout_w = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            rd_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
        end else begin
            // Writeback fields are only non-zero during DONE.
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        opa_q    <= issue_opA;
                        opb_q    <= issue_opB;
                        rd_q     <= issue_rd;
                        is_div_q <= issue_is_div;
                        state_q  <= START;
                    end
                end
                START: begin
                    state_q <= flush ? IDLE : BUSY;
                end
                BUSY: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (md_resultRDY) begin
                        state_q <= DONE;
                        if (md_exception) begin
                            wb_rd_q   <= RSTATUS_REG;
                            wb_data_q <= exc_status(is_div_q);
                            wb_exc_q  <= 1'b1;
                        end else begin
                            wb_rd_q   <= rd_q;
                            wb_data_q <= md_result;
                        end
                    end else if (timeout_w) begin
                        state_q   <= DONE;
                        wb_rd_q   <= RSTATUS_REG;
                        wb_data_q <= STATUS_TIMEOUT;
                        wb_exc_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_ctrl_MULT = (state_q == START) && !is_div_q;
    assign md_ctrl_DIV  = (state_q == START) && is_div_q;

    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            IDLE:    stall = accept;
            START:   stall = 1'b1;
            BUSY:    stall = 1'b1;
            DONE:    stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    assign wb_valid     = (state_q == DONE) && !flush;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_exception = wb_exc_q;

endmodule

// File: doc/multdiv_issue.md
# multdiv_issue

Processor-side initiator for the iterative multiply/divide unit. It sits in the execute stage and accepts a MULT or DIV instruction. It latches the operands and destination, sends a single start pulse, and stalls the pipeline until the result-ready signal arrives. It then presents a one-cycle writeback (or $rstatus exception write) to the writeback stage.

## Interface
- TIMEOUT_CYCLES, 64: BUSY cycles before the watchdog aborts (used only with the macro).
- RSTATUS_REG, 30: register index written on exception.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  execute stage holds a MULT/DIV instruction.
- issue_is_div  in  1  1 = DIV, 0 = MULT.
- issue_opA, issue_opB  in  32  operands.
- issue_rd  in  5  destination register.
- flush  in  1  squash the held/in-flight op.
- md_operandA, md_operandB  out  32  registered operands to multdiv.
- md_ctrl_MULT, md_ctrl_DIV  out  1  one-cycle start pulses.
- md_result  in  32  result from multdiv.
- md_exception  in  1  exception from multdiv.
- md_resultRDY  in  1  result ready from multdiv.
- stall  out  1  freeze fetch/decode/execute.
- wb_valid  out  1  writeback strobe.
- wb_rd  out  5  writeback destination.
- wb_data  out  32  writeback value.
- wb_exception  out  1  this writeback is an $rstatus write.

## Operation
- FSM states are IDLE, START, BUSY, DONE. Reset enters IDLE. All registered outputs reset to 0, and md_operandA/B reset to 0.
- IDLE
  - issue_valid && !flush: latch opA, opB, rd and is_div, then go to START.
  - stall = issue_valid && !flush, combinationally, in the same cycle.
- START
  - Exactly one of md_ctrl_MULT/md_ctrl_DIV is high, selected by latched is_div. Go to BUSY.
  - stall = 1.
- BUSY
  - stall = 1.
  - On md_resultRDY: capture md_result and md_exception, then go to DONE.
- DONE
  - wb_valid = 1 and stall = 0, so the instruction leaves execute at the end of this cycle. Go to IDLE.
  - issue_valid is ignored in this cycle.
- Writeback data:
  - No exception: wb_rd = latched rd, wb_data = captured result, wb_exception = 0.
  - Exception: wb_rd = RSTATUS_REG, wb_data = 4 (MULT) or 5 (DIV), wb_exception = 1.
- Flush:
  - In START or BUSY: go to IDLE, with no wb_valid. The multdiv result is discarded; the next start pulse restarts the unit.
  - In DONE: wb_valid is forced to 0.
  - In IDLE: the op is not accepted.
- md_resultRDY is ignored outside BUSY. This covers a stale ready from a squashed op that arrives during START.
- md_operandA/B hold their latched values from acceptance until the next acceptance.
- Reset mid-operation: asynchronous return to IDLE. Pulses, stall and wb_valid drop immediately.

## Timing
- Acceptance happens in cycle t. START (pulse) is t+1, and BUSY begins at t+2.
- If md_resultRDY is first seen in BUSY at cycle r, wb_valid is high at r+1.
- Minimum issue-to-writeback latency is 3 cycles.
- stall is high from t through r inclusive and low in r+1.
- Back-to-back ops: the next op is accepted no earlier than the cycle after DONE.
- Start pulse width is always exactly 1 cycle. MULT and DIV pulses are never high together.

## Configuration
- Macro: MULTDIV_ISSUE_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY. It clears on entry and counts each cycle without md_resultRDY.
  - On reaching TIMEOUT_CYCLES, go to DONE with wb_exception = 1, wb_rd = RSTATUS_REG, wb_data = 6.
  - If md_resultRDY arrives in the same cycle the counter reaches TIMEOUT_CYCLES, md_resultRDY wins.
- Undefined: no counter. BUSY waits indefinitely.

## Structure
- Shared package multdiv_pkg holds:
  - the state enum (IDLE/START/BUSY/DONE);
  - status codes STATUS_MULT_OVF = 4, STATUS_DIV_EXC = 5, STATUS_TIMEOUT = 6;
  - the default RSTATUS_REG = 30.
- One sub-module, multdiv_watchdog, contains the BUSY counter and timeout flag. It is instantiated only under the macro.

## Test plan
- MULT 7×6, rd=5, against the real multdiv: one pulse on md_ctrl_MULT; stall holds until ready; then wb_valid=1, wb_rd=5, wb_data=42, wb_exception=0, and stall=0 in the same cycle.
- MULT 0x40000000×4, rd=8 (overflow): wb_rd=30, wb_data=4, wb_exception=1.
- DIV 100/0, rd=9: wb_rd=30, wb_data=5, wb_exception=1. Then DIV 100/7, rd=9: wb_data=14, no exception.
- DIV 9/3 flushed in BUSY cycle 5: no wb_valid, stall drops next cycle. An immediate MULT -3×5, rd=2, then gives wb_data=0xFFFFFFF1.
- Assert reset_n low in BUSY: all outputs go to 0 asynchronously. The next op after release completes correctly.
- With MULTDIV_ISSUE_TIMEOUT_EN, a stub that never asserts ready: wb_valid is seen 64 BUSY cycles after entry, with wb_rd=30, wb_data=6, wb_exception=1.
